ysyx_24110026_bus_arb: RTL and testbench
========================================

# ysyx_24110026_bus_arb

Two-master, one-slave memory arbiter for the RV32E core. It lets the instruction fetch unit (IFU) and the load/store unit (LSU) share a single memory port, with one outstanding transaction at a time. Ties are broken by two-way round-robin, and a response watchdog covers slow slaves. It sits between the core's IFU/LSU and the memory/SoC bus, and it is what paces `pc_en` in the multi-cycle core.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- TIMEOUT, 255, cycles to wait in RSP before an error response; 0 disables the watchdog

Ports:
- Clock and reset: clk, rst. Reset is synchronous and active-high; clock is clk.
  - clk  in  1  clock
  - rst  in  1  synchronous reset, active-high
- IFU request channel:
  - if_req_valid  in  1  IFU request
  - if_req_ready  out  1  IFU request accepted this cycle
  - if_addr  in  ADDR_W  fetch address
- IFU response channel:
  - if_rsp_valid  out  1  IFU response, one-cycle pulse
  - if_rsp_data  out  DATA_W  fetched word
  - if_rsp_err  out  1  error or timeout
- LSU request channel:
  - ls_req_valid  in  1  LSU request
  - ls_req_ready  out  1  LSU request accepted
  - ls_addr  in  ADDR_W  load/store address
  - ls_wen  in  1  1 = store
  - ls_wdata  in  DATA_W  store data
  - ls_wmask  in  DATA_W/8  byte strobes
- LSU response channel:
  - ls_rsp_valid  out  1  LSU response pulse
  - ls_rsp_data  out  DATA_W  load data
  - ls_rsp_err  out  1  error or timeout
- Memory request channel:
  - mem_req_valid  out  1  request to slave
  - mem_req_ready  in  1  slave accepts
  - mem_addr  out  ADDR_W  registered address
  - mem_wen  out  1  registered write flag
  - mem_wdata  out  DATA_W  registered write data
  - mem_wmask  out  DATA_W/8  registered write strobes
- Memory response channel:
  - mem_rsp_valid  in  1  slave response
  - mem_rsp_data  in  DATA_W  response data
  - mem_rsp_err  in  1  slave error
- Status:
  - busy  out  1  state != IDLE
  - stale_err  out  1  sticky flag; a response arrived outside RSP

## Operation
- FSM has three states: IDLE, REQ and RSP.
- **IDLE**
  - If only one master is valid, that master wins.
  - If both are valid, the master not granted last wins.
  - The winner's `*_req_ready` is driven high combinationally; the loser's stays low.
  - On the handshake, latch owner, addr, wen, wdata and wmask, then go to REQ. IFU requests latch wen = 0 and wmask = 0.
- **REQ**
  - mem_req_valid = 1, driven from the latched registers.
  - When mem_req_ready = 1, go to RSP and clear the watchdog counter.
- **RSP**
  - Wait for mem_rsp_valid. On arrival, forward it combinationally to the owner:
    - owner `*_rsp_valid` = 1
    - data = mem_rsp_data
    - err = mem_rsp_err
  - Update last_grant to the owner and return to IDLE.
  - The non-owner's rsp_valid stays 0.
- **Watchdog**
  - The counter increments each cycle in RSP.
  - When count == TIMEOUT with no response, emit a one-cycle owner response with data = 0 and err = 1, then go to IDLE.
- **Stray responses**
  - mem_rsp_valid in IDLE or REQ is dropped and sets stale_err.
  - stale_err clears only on rst.
- **Master rules**
  - Masters hold valid and payload stable until ready.
  - Masters always accept responses; there is no rsp_ready.
- The arbiter never issues a new request while RSP is pending.

## Timing
- **Reset values:** state = IDLE; last_grant = IFU, so the first tie goes to the LSU. All ready, valid, err, data and status outputs are 0, and the counter is 0.
- **Request path:** a request accepted in cycle T has mem_req_valid = 1 from cycle T+1.
- **Response path:** zero cycles. The response appears in the same cycle as mem_rsp_valid.
- **Best-case occupancy:** 3 cycles per transaction (IDLE, REQ, RSP with immediate acks). The next grant is possible in the cycle after the response.
- **Reset mid-transaction:** the transaction is aborted with no response pulse and no further mem_req_valid. The slave side is expected to reset together with the arbiter.
- **Watchdog sizing:**
  - The counter is $clog2(TIMEOUT+1) bits wide.
  - With TIMEOUT = N, the error pulse is N cycles after entering RSP.
  - A response landing in the same cycle as count == TIMEOUT wins: the real data is delivered with no timeout error.
- **Arbitration timing:** simultaneous new requests while busy stay pending and are arbitrated only in IDLE.

## Structure
- **Shared package ysyx_24110026_bus_pkg:**
  - state enum {IDLE, REQ, RSP}
  - owner enum {OWN_IF, OWN_LS}
  - default widths
- **Sub-module ysyx_24110026_rr_pick2:** combinational two-way round-robin picker. Inputs are two valids and last_grant; outputs are the one-hot grant.
- **In-block registers:** payload registers and the watchdog counter live in the arbiter itself.

## Test plan
- **Lone IFU:** if_req_valid with addr 0x80000000. Expect ready in cycle T, mem_req_valid at T+1. Slave acks immediately and returns 0x00000413. Expect if_rsp_valid with data 0x00000413, err = 0.
- **Tie out of reset:** both masters valid. Expect the LSU granted first (store 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_wen = 1). The IFU is granted next, then alternation continues on every subsequent tie.
- **Held request:** the LSU requests while an IFU transaction is in REQ with mem_req_ready held low for 5 cycles. Expect ls_req_ready = 0 throughout, mem_addr stable, and the LSU granted after the IFU response.
- **Timeout:** TIMEOUT = 8 and the slave never responds. Expect the owner rsp_valid with err = 1 and data 0 exactly 8 cycles after RSP entry. A late mem_rsp_valid afterwards sets stale_err = 1.
- **Reset mid-transaction:** assert rst in RSP. Expect no rsp pulse and all outputs 0 next cycle. A fresh IFU request afterwards completes normally.

Source files
------------

// File: rtl/ysyx_24110026_bus_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
package ysyx_24110026_bus_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } bus_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/ysyx_24110026_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that was not granted last.
module ysyx_24110026_rr_pick2
    import ysyx_24110026_bus_pkg::*;
(
    input  logic   req_if,
    input  logic   req_ls,
    input  owner_t last_grant,
    output logic   grant_if,
    output logic   grant_ls
);

    // One-hot grant; on a tie the previous owner yields to the other master
    always_comb begin
        grant_if = req_if && (!req_ls || (last_grant == OWN_LS));
        grant_ls = req_ls && (!req_if || (last_grant == OWN_IF));
    end

endmodule

// File: rtl/ysyx_24110026_bus_arb.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with one outstanding
// transaction, round-robin tie breaking and a response watchdog.
module ysyx_24110026_bus_arb
    import ysyx_24110026_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,

    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_rsp_err,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,

    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                ls_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,

    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err,

    output logic                busy,
    output logic                stale_err
);

    // A zero TIMEOUT disables the watchdog but still needs a legal counter width
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

    bus_state_t          state;
    owner_t              owner;
    owner_t              last_grant;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [CNT_W-1:0]    wd_cnt;
    logic                stale_q;

    logic                grant_if;
    logic                grant_ls;
    logic                timeout_hit;
    logic                rsp_fire;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    ysyx_24110026_rr_pick2 u_pick (
        .req_if     (if_req_valid),
        .req_ls     (ls_req_valid),
        .last_grant (last_grant),
        .grant_if   (grant_if),
        .grant_ls   (grant_ls)
    );

    // Watchdog expiry and response selection; a real response beats a timeout
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (state == RSP) && (wd_cnt == TIMEOUT_VAL);
        rsp_fire    = (state == RSP) && (mem_rsp_valid || timeout_hit);
        rsp_data    = mem_rsp_valid ? mem_rsp_data : '0;
        rsp_err     = mem_rsp_valid ? mem_rsp_err  : 1'b1;
    end

    // Request readies and response routing to the current owner
    always_comb begin
        if_req_ready = (state == IDLE) && grant_if;
        ls_req_ready = (state == IDLE) && grant_ls;
        if_rsp_valid = rsp_fire && (owner == OWN_IF);
        ls_rsp_valid = rsp_fire && (owner == OWN_LS);
        if_rsp_data  = if_rsp_valid ? rsp_data : '0;
        if_rsp_err   = if_rsp_valid && rsp_err;
        ls_rsp_data  = ls_rsp_valid ? rsp_data : '0;
        ls_rsp_err   = ls_rsp_valid && rsp_err;
    end

    // Memory-side request and status outputs come straight from registers
    always_comb begin
        mem_req_valid = (state == REQ);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        busy          = (state != IDLE);
        stale_err     = stale_q;
    end

    // Arbiter FSM with payload latching, watchdog counter and stray-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            wd_cnt     <= '0;
            stale_q    <= 1'b0;
        end else begin
            if (mem_rsp_valid && (state != RSP)) begin
                stale_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        owner   <= OWN_IF;
                        addr_q  <= if_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        state   <= REQ;
                    end else if (grant_ls) begin
                        owner   <= OWN_LS;
                        addr_q  <= ls_addr;
                        wen_q   <= ls_wen;
                        wdata_q <= ls_wdata;
                        wmask_q <= ls_wmask;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        wd_cnt <= '0;
                        state  <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid || timeout_hit) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110026_bus_arb.sv
// Directed self-checking bench for the IFU/LSU memory arbiter.
module tb_ysyx_24110026_bus_arb;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        busy;
    logic        stale_err;

    int checks;
    int failures;

    ysyx_24110026_bus_arb #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_wen        (ls_wen),
        .ls_wdata      (ls_wdata),
        .ls_wmask      (ls_wmask),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .ls_rsp_err    (ls_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .busy          (busy),
        .stale_err     (stale_err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Compare one observed value with its expected value and count it
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive both master request channels
    task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                 input logic lv, input logic [31:0] la,
                                 input logic lw, input logic [31:0] ld,
                                 input logic [3:0] lm);
        if_req_valid = iv;
        if_addr      = ia;
        ls_req_valid = lv;
        ls_addr      = la;
        ls_wen       = lw;
        ls_wdata     = ld;
        ls_wmask     = lm;
    endtask

    // From IDLE with requests already driven: check the grant, the memory
    // request, then answer at once and check the routed response
    task automatic grantAndServe(input string tag, input logic expLs,
                                 input logic [31:0] expAddr, input logic expWen,
                                 input logic [31:0] expWdata, input logic [3:0] expWmask,
                                 input logic [31:0] rdata, input logic rerr);
        #1;
        checkOutput({tag, "_if_ready"}, if_req_ready, !expLs);
        checkOutput({tag, "_ls_ready"}, ls_req_ready, expLs);
        @(negedge clk);
        if (expLs) ls_req_valid = 1'b0;
        else       if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkOutput({tag, "_mem_valid"}, mem_req_valid, 1'b1);
        checkOutput({tag, "_mem_addr"}, mem_addr, expAddr);
        checkOutput({tag, "_mem_wen"}, mem_wen, expWen);
        checkOutput({tag, "_mem_wmask"}, mem_wmask, expWmask);
        if (expWen) checkOutput({tag, "_mem_wdata"}, mem_wdata, expWdata);
        checkOutput({tag, "_busy_ready"}, {if_req_ready, ls_req_ready}, 2'b00);
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rdata;
        mem_rsp_err   = rerr;
        #1;
        checkOutput({tag, "_rsp_valid"}, {if_rsp_valid, ls_rsp_valid}, expLs ? 2'b01 : 2'b10);
        checkOutput({tag, "_rsp_data"}, expLs ? ls_rsp_data : if_rsp_data, rdata);
        checkOutput({tag, "_rsp_err"}, expLs ? ls_rsp_err : if_rsp_err, rerr);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        #1;
        checkOutput({tag, "_idle"}, {busy, if_rsp_valid, ls_rsp_valid}, 3'b000);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_mem_valid", mem_req_valid, 1'b0);
        checkOutput("rst_stale", stale_err, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_readies", {if_req_ready, ls_req_ready}, 2'b00);
        checkOutput("rst_rsp", {if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data}, 66'h0);
        rst = 1'b0;

        // Ties out of reset alternate LSU, IFU, LSU, IFU; then a lone LSU load with slave error
        applyStimulus(1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        grantAndServe("tie0", 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0004, 1'b1, 32'h8000_1004, 1'b1, 32'h1234_5678, 4'h3);
        grantAndServe("tie1", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1'b0);
        applyStimulus(1'b1, 32'h8000_0008, 1'b1, 32'h8000_1004, 1'b1, 32'h1234_5678, 4'h3);
        grantAndServe("tie2", 1'b1, 32'h8000_1004, 1'b1, 32'h1234_5678, 4'h3, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0008, 1'b1, 32'h8000_1008, 1'b0, 32'h0, 4'h0);
        grantAndServe("tie3", 1'b0, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 32'h0000_0093, 1'b0);
        grantAndServe("ls_err", 1'b1, 32'h8000_1008, 1'b0, 32'h0, 4'h0, 32'hBAD0_BAD0, 1'b1);

        // Lone IFU fetch
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        grantAndServe("lone_if", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1'b0);

        // LSU held off while the IFU request waits five cycles for the slave
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("held_if_ready", if_req_ready, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("held_ls_ready", ls_req_ready, 1'b0);
            checkOutput("held_mem_addr", mem_addr, 32'h8000_0020);
            checkOutput("held_mem_valid", mem_req_valid, 1'b1);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        #1;
        checkOutput("held_ack_addr", mem_addr, 32'h8000_0020);
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_CAFE;
        #1;
        checkOutput("held_if_rsp", {if_rsp_valid, ls_rsp_valid, ls_req_ready}, 3'b100);
        checkOutput("held_if_data", if_rsp_data, 32'h0000_CAFE);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        grantAndServe("held_ls", 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 32'h1111_2222, 1'b0);

        // Response arriving in the same cycle the watchdog expires wins
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_4000, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("edge_ls_ready", ls_req_ready, 1'b1);
        @(negedge clk);
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (8) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5A5A_5A5A;
        mem_rsp_err   = 1'b0;
        #1;
        checkOutput("edge_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 2'b01);
        checkOutput("edge_rsp_data", ls_rsp_data, 32'h5A5A_5A5A);
        checkOutput("edge_rsp_err", ls_rsp_err, 1'b0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        checkOutput("edge_idle_stale", {busy, stale_err}, 2'b00);

        // Slave never answers: error pulse exactly 8 cycles after RSP entry
        applyStimulus(1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("to_if_ready", if_req_ready, 1'b1);
        @(negedge clk);
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        checkOutput("to_wait0", if_rsp_valid, 1'b0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            #1;
            checkOutput("to_wait", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        end
        @(negedge clk);
        #1;
        checkOutput("to_pulse", {if_rsp_valid, ls_rsp_valid}, 2'b10);
        checkOutput("to_err", if_rsp_err, 1'b1);
        checkOutput("to_data", if_rsp_data, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("to_idle", {busy, if_rsp_valid, stale_err}, 3'b000);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        #1;
        checkOutput("late_no_pulse", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        checkOutput("late_stale", stale_err, 1'b1);

        // Reset while waiting in RSP aborts silently
        applyStimulus(1'b1, 32'h8000_0030, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("rmid_if_ready", if_req_ready, 1'b1);
        @(negedge clk);
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rmid_busy_before", {busy, if_rsp_valid}, 2'b10);
        @(negedge clk);
        #1;
        checkOutput("rmid_state", {busy, mem_req_valid, stale_err, if_rsp_valid, if_req_ready}, 5'b0);
        checkOutput("rmid_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        grantAndServe("post_rst", 1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
